// File: rtl/mem_pkg.sv
// Shared constants and types for the multi-cycle data-memory responder.
// Holds the FSM encoding, access-size codes and the index-width helper.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    function automatic int idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian byte-lane steering for the data memory.
// Merges store bytes into the old word and extracts/extends load bytes.
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  i_lane,
    input  logic        i_byte,
    input  logic        i_sext,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_wword,
    output logic [31:0] o_rword
);

    logic [7:0] w_sel;
    logic [31:0] w_merge;

    always_comb begin
        w_sel   = i_old_word[7:0];
        w_merge = i_old_word;
        unique case (i_lane)
            2'd0: begin
                w_sel         = i_old_word[7:0];
                w_merge[7:0]  = i_wdata[7:0];
            end
            2'd1: begin
                w_sel          = i_old_word[15:8];
                w_merge[15:8]  = i_wdata[7:0];
            end
            2'd2: begin
                w_sel          = i_old_word[23:16];
                w_merge[23:16] = i_wdata[7:0];
            end
            default: begin
                w_sel          = i_old_word[31:24];
                w_merge[31:24] = i_wdata[7:0];
            end
        endcase
    end

    always_comb begin
        if (i_byte == SIZE_BYTE) begin
            o_wword = w_merge;
            o_rword = {{24{i_sext & w_sel[7]}}, w_sel};
        end else begin
            o_wword = i_wdata;
            o_rword = i_old_word;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target for the MEM stage: fixed-latency
// service of lw/lb/lbu/sw/sb with a pipeline stall until the response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        WriteEn,
    input  logic        Byte,
    input  logic        SignExt,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic        Ready,
    output logic [31:0] ReadData,
    output logic        AddrError
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);
    localparam int AW    = IDX_W + 2;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic ONE_CYCLE = (LATENCY == 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic              r_byte;
    logic              r_sext;
    logic [AW-1:0]     r_addr;
    logic [31:0]       r_wdata;
    logic              r_ready;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_idle;
    logic              w_op_we;
    logic              w_op_byte;
    logic              w_op_sext;
    logic [AW-1:0]     w_op_addr;
    logic [31:0]       w_op_wdata;
    logic [IDX_W-1:0]  w_idx;
    logic              w_misalign;
    logic              w_enter_resp;
    logic              w_mem_we;
    logic [31:0]       w_old_word;
    logic [31:0]       w_wword;
    logic [31:0]       w_rword;
    logic              w_unused;

    // Address bits above the index field deliberately alias (wrap).
    assign w_unused = &{1'b0, Address[31:AW]};

    assign w_idle = (r_state == IDLE);

    // With single-cycle latency the array is accessed on the accept edge,
    // before the latched copy exists, so the live inputs are used.
    assign w_op_we    = w_idle ? WriteEn : r_we;
    assign w_op_byte  = w_idle ? Byte : r_byte;
    assign w_op_sext  = w_idle ? SignExt : r_sext;
    assign w_op_addr  = w_idle ? Address[AW-1:0] : r_addr;
    assign w_op_wdata = w_idle ? WriteData : r_wdata;

    assign w_idx      = w_op_addr[AW-1:2];
    assign w_misalign = (w_op_byte == SIZE_WORD) &&
                        (w_op_addr[1:0] != 2'b00);

    assign w_enter_resp = !Rst &&
        ((w_idle && Req && ONE_CYCLE) ||
         ((r_state == WAIT) && (r_cnt == '0)));

    assign w_mem_we   = w_enter_resp && w_op_we && !w_misalign;
    assign w_old_word = r_mem[w_idx];

    byte_lane_unit u_lane (
        .i_lane     (w_op_addr[1:0]),
        .i_byte     (w_op_byte),
        .i_sext     (w_op_sext),
        .i_old_word (w_old_word),
        .i_wdata    (w_op_wdata),
        .o_wword    (w_wword),
        .o_rword    (w_rword)
    );

    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_wword;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (Req) begin
                        r_we    <= WriteEn;
                        r_byte  <= Byte;
                        r_sext  <= SignExt;
                        r_addr  <= Address[AW-1:0];
                        r_wdata <= WriteData;
                        if (ONE_CYCLE) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_enter_resp) begin
                r_ready <= 1'b1;
                r_err   <= w_misalign;
                r_rdata <= (w_op_we || w_misalign) ? 32'd0 : w_rword;
            end
        end
    end

    assign Stall     = !Rst && ((w_idle && Req) || (r_state == WAIT));
    assign Ready     = r_ready;
    assign ReadData  = r_rdata;
    assign AddrError = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for the
// main access/alignment/wrap/reset tests, LATENCY=1 instance for Req hold.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req0 = 1'b0, we0 = 1'b0, byt0 = 1'b0, sx0 = 1'b0;
    logic [31:0] addr0 = '0, wd0 = '0;
    logic        stall0, ready0, err0;
    logic [31:0] rd0;

    logic        req1 = 1'b0, we1 = 1'b0, byt1 = 1'b0, sx1 = 1'b0;
    logic [31:0] addr1 = '0, wd1 = '0;
    logic        stall1, ready1, err1;
    logic [31:0] rd1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
        .Clk(clk), .Rst(rst), .Req(req0), .WriteEn(we0), .Byte(byt0),
        .SignExt(sx0), .Address(addr0), .WriteData(wd0),
        .Stall(stall0), .Ready(ready0), .ReadData(rd0), .AddrError(err0)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .Clk(clk), .Rst(rst), .Req(req1), .WriteEn(we1), .Byte(byt1),
        .SignExt(sx1), .Address(addr1), .WriteData(wd1),
        .Stall(stall1), .Ready(ready1), .ReadData(rd1), .AddrError(err1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One LATENCY=2 transaction: stall in cycles 0..1, response in cycle 2.
    task automatic access(input string tag, input logic we, input logic byt,
                          input logic sx, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err);
        @(negedge clk);
        req0 = 1'b1; we0 = we; byt0 = byt; sx0 = sx;
        addr0 = addr; wd0 = wd;
        #1;
        check({tag, ".stall_c0"}, stall0, 1);
        @(negedge clk);
        req0 = 1'b0;
        #1;
        check({tag, ".stall_c1"}, stall0, 1);
        check({tag, ".ready_c1"}, ready0, 0);
        @(negedge clk);
        check({tag, ".ready_c2"}, ready0, 1);
        check({tag, ".stall_c2"}, stall0, 0);
        check({tag, ".rdata"}, rd0, exp_rd);
        check({tag, ".err"}, err0, exp_err);
    endtask

    initial begin
        req0 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.stall", stall0, 0);
        check("rst.ready", ready0, 0);
        check("rst.rdata", rd0, 0);
        check("rst.err", err0, 0);
        req0 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle.stall", stall0, 0);

        access("sw10", 1, 0, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        access("lw10", 0, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        access("sb11", 1, 1, 0, 32'h11, 32'h000000A5, 32'h0, 0);
        access("lw10b", 0, 0, 0, 32'h10, 32'h0, 32'hDEADA5EF, 0);
        access("lb11", 0, 1, 1, 32'h11, 32'h0, 32'hFFFFFFA5, 0);
        access("lbu11", 0, 1, 0, 32'h11, 32'h0, 32'h000000A5, 0);
        access("lb10", 0, 1, 1, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
        access("lw12", 0, 0, 0, 32'h12, 32'h0, 32'h0, 1);
        access("lw10c", 0, 0, 0, 32'h10, 32'h0, 32'hDEADA5EF, 0);
        access("sw1010", 1, 0, 0, 32'h1010, 32'h12345678, 32'h0, 0);
        access("lw10w", 0, 0, 0, 32'h10, 32'h0, 32'h12345678, 0);
        access("sw12", 1, 0, 0, 32'h12, 32'h11111111, 32'h0, 1);
        access("lw10d", 0, 0, 0, 32'h10, 32'h0, 32'h12345678, 0);
        access("lbu13", 0, 1, 0, 32'h13, 32'h0, 32'h00000012, 0);

        // Reset during WAIT of a store must abort the write.
        access("sw20z", 1, 0, 0, 32'h20, 32'h0, 32'h0, 0);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; byt0 = 1'b0; addr0 = 32'h20;
        wd0 = 32'h55AA55AA;
        @(negedge clk);
        req0 = 1'b0;
        rst = 1'b1;
        #1;
        check("abort.stall", stall0, 0);
        check("abort.ready0", ready0, 0);
        @(negedge clk);
        check("abort.ready1", ready0, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort.ready2", ready0, 0);
        check("abort.stall2", stall0, 0);
        access("lw20", 0, 0, 0, 32'h20, 32'h0, 32'h0, 0);

        // LATENCY=1 with Req held through RESP, then a new load.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; byt1 = 1'b0; addr1 = 32'h40;
        wd1 = 32'hCAFEF00D;
        #1;
        check("l1.sw.stall", stall1, 1);
        check("l1.sw.ready0", ready1, 0);
        @(negedge clk);
        check("l1.sw.ready", ready1, 1);
        check("l1.sw.stall_resp", stall1, 0);
        check("l1.sw.rdata", rd1, 0);
        check("l1.sw.err", err1, 0);
        we1 = 1'b0;
        @(negedge clk);
        check("l1.lw.stall", stall1, 1);
        check("l1.lw.ready0", ready1, 0);
        @(negedge clk);
        check("l1.lw.ready", ready1, 1);
        check("l1.lw.stall_resp", stall1, 0);
        check("l1.lw.rdata", rd1, 32'hCAFEF00D);
        req1 = 1'b0;
        @(negedge clk);
        check("l1.idle.ready", ready1, 0);
        check("l1.idle.stall", stall1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder. It is the target end of the MEM-stage load/store interface.
- The pipeline's Memory stage issues requests (lw, lb, lbu, sw, sb). This block services them after a fixed latency and asserts Stall, so the hazard logic freezes PC, IF_ID and the downstream pipeline registers until the response.
- It replaces the single-cycle combinational data memory. The block owns the word array, the byte-lane steering and alignment checking.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words. Must be a power of two. Index = Address[log2(DEPTH_WORDS)+1:2].
- LATENCY, 2: cycles from request acceptance to the Ready pulse. Must be >= 1.

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-high
- Req  in  1  request valid from the MEM stage (MemRead | MemWrite)
- WriteEn  in  1  1 = store, 0 = load
- Byte  in  1  1 = byte access (lb/lbu/sb), 0 = word access
- SignExt  in  1  byte loads only: 1 = sign-extend (lb), 0 = zero-extend (lbu)
- Address  in  32  byte address (ALU result)
- WriteData  in  32  store data; for sb, bits [7:0] are used
- Stall  out  1  combinational; 1 = hold all pipeline stages
- Ready  out  1  one-cycle response pulse
- ReadData  out  32  registered load data, valid while Ready=1
- AddrError  out  1  registered; qualifies Ready; misaligned word access

Behaviour:
- Reset values: Ready=0, ReadData=0, AddrError=0, state=IDLE, latency counter=0.
- Stall is forced to 0 while Rst=1. The array contents are NOT reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If Req=1, latch WriteEn, Byte, SignExt, Address and WriteData.
  - If LATENCY=1, go to RESP; otherwise go to WAIT with counter=LATENCY-2.
  - Stall = Req in the same cycle, so the pipeline freezes on the request cycle itself.
- WAIT:
  - Stall=1.
  - Counter decrements. When it reaches 0, go to RESP.
  - Req and operand inputs are ignored; only the latched copy is used.
- Array access occurs on the clock edge that enters RESP:
  - Store: word or byte write.
  - Load: ReadData registered.
- RESP:
  - Ready=1 and Stall=0 for exactly one cycle, so the pipeline advances.
  - Next state is IDLE unconditionally. A Req seen during RESP is not accepted, because it belongs to the same instruction.
- Latency: with Req sampled in IDLE at cycle 0, Ready is high in cycle LATENCY. Stall is high in cycles 0..LATENCY-1.
- Byte lanes are little-endian, lane = Address[1:0].
  - sb writes only the selected lane; the other three bytes are unchanged.
  - lb/lbu return the selected byte in [7:0], with [31:8] = sign or zero fill.
- Misaligned word access (Byte=0 and Address[1:0]!=0):
  - No write.
  - ReadData=0, AddrError=1 in the RESP cycle.
  - Byte accesses are never misaligned.
- Address bits above the index field are ignored, so accesses wrap modulo DEPTH_WORDS*4.
- Store response: ReadData=0, AddrError=0 unless misaligned.
- Reset mid-operation (WAIT, or RESP not yet entered): the pending store is aborted with no array write. Return to IDLE, no Ready pulse.
- Back-to-back requests: the earliest next acceptance is the cycle after RESP, so the sustained rate is one access per LATENCY+1 cycles.
- Ready and AddrError are deasserted in every cycle other than RESP.

Decomposition:
- Shared package mem_pkg holds:
  - State encoding constants: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Access-size constants: SIZE_WORD=1'b0, SIZE_BYTE=1'b1.
  - Helper constant for index width.
- One combinational sub-module, byte_lane_unit. Inputs: lane, Byte, SignExt, old word, store data. Outputs: merged write word and extracted/extended load word.

Test Plan:
- LATENCY=2; sw Address=0x10, WriteData=0xDEADBEEF, then lw 0x10 -> Stall high 2 cycles per access, Ready in cycle 2, ReadData=0xDEADBEEF, AddrError=0.
- After the above, sb Address=0x11, WriteData=0x000000A5; lw 0x10 -> 0xDEADA5EF. lb 0x11 -> 0xFFFFFFA5. lbu 0x11 -> 0x000000A5. lb 0x10 -> 0xFFFFFFEF.
- lw Address=0x12 -> Ready with AddrError=1, ReadData=0. A following lw 0x10 still returns 0xDEADA5EF, so no corruption occurred.
- DEPTH_WORDS=1024; sw Address=0x1010, WriteData=0x12345678 -> lw 0x10 returns 0x12345678 (wrap).
- Rst pulsed during WAIT of sw 0x20, WriteData=0x55AA55AA, with prior content 0 -> no Ready pulse, Stall=0 during reset; lw 0x20 returns 0.
- LATENCY=1; Req held high through RESP, then a new lw -> Ready exactly once per request, Stall high exactly 1 cycle per access, and no double write of the store.
